// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: one load/store per request, req/ack bus handshake,
// byte-lane generation and load extension. Optional misalignment abort via MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        misalign_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we, r_sign, r_err, r_mis;
    logic [1:0]  r_size, r_off;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;

    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_lane, w_ldata;
    logic        w_misalign;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (size_i == 2'b01 && addr_i[0]) || (size_i[1] && addr_i[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
        case (size_i)
            2'b00: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {addr_i[1], 1'b0};
                w_wdata = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Halfwords ignore the low offset bit, so only bytes use r_off[0] for the lane shift.
    always_comb begin
        w_lane  = bus_rdata_i >> {r_off[1], (r_size == 2'b00) & r_off[0], 3'b000};
        w_ldata = bus_rdata_i;
        case (r_size)
            2'b00:   w_ldata = {{24{r_sign & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_ldata = {{16{r_sign & w_lane[15]}}, w_lane[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_sign  <= 1'b0;
            r_size  <= '0;
            r_off   <= '0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_i) begin
                    r_we    <= we_i;
                    r_sign  <= sign_i;
                    r_size  <= size_i;
                    r_off   <= addr_i[1:0];
                    r_addr  <= {addr_i[31:2], 2'b00};
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_cnt   <= '0;
                    if (w_misalign) begin
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                        r_mis   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_ack_i) begin
                        r_state <= S_DONE;
                        r_rdata <= r_we ? 32'd0 : w_ldata;
                        r_err   <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_mis   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall_o     = (r_state == S_REQ) || (r_state == S_IDLE && req_i);
    assign done_o      = (r_state == S_DONE);
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;
    assign misalign_o  = r_mis;
    assign bus_req_o   = (r_state == S_REQ);
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_be_o    = r_be;
    assign bus_wdata_o = r_wdata;
endmodule
